// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI NOR flash target.
// Commands, FSM state encoding and address-phase length.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_JEDEC_ID  = 8'h9F;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_ID     = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam int ADDR_LEN = 24;

endpackage

// File: rtl/spi_sync_edge.sv
// Input synchroniser for a pad signal plus rise/fall detection
// on the synchronised value. STAGES must be at least 2.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_b,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 serial NOR flash emulator (READ, JEDEC ID).
// Define FAST_READ_EN to also accept FAST READ (0x0B).
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W      = 19,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4013,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              spi_sck,
  input  logic              spi_cs_b,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              underrun
);

  logic sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q;
  logic cs_s, mosi_s;

  logic [2:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [23:0]       sin_q, sin_d;
  logic [23:0]       sout_q, sout_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              unr_q, unr_d;
  logic              rdy_q, rdy_d;
  logic              fast_q, fast_d;

  logic [23:0] word_v;
  logic [7:0]  byte_v;
  logic [3:0]  sh_v;
  logic        is_read_v, is_id_v, is_fast_v;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sck (
    .clock   (clock),
    .reset_b (reset_b),
    .d_i     (spi_sck),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    sin_d   = sin_q;
    sout_d  = sout_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unr_d   = unr_q;
    rdy_d   = rdy_q;
    fast_d  = fast_q;
    word_v    = {sin_q[22:0], mosi_s};
    is_read_v = (word_v[7:0] == CMD_READ);
    is_id_v   = (word_v[7:0] == CMD_JEDEC_ID);
`ifdef FAST_READ_EN
    is_fast_v = (word_v[7:0] == CMD_FAST_READ);
`else
    is_fast_v = 1'b0;
`endif
    sh_v   = fcnt_q + {3'b000, (state_q == ST_DATA) & sck_fall};
    byte_v = mem_data << sh_v;

    if (req_q && mem_ack) req_d = 1'b0;
    if (sck_rise) sin_d = word_v;

    if (cs_s) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_d   = '0;
      fcnt_d  = '0;
      unr_d   = 1'b0;
      rdy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            unique case (1'b1)
              is_read_v | is_fast_v: begin
                state_d = ST_ADDR;
                fast_d  = is_fast_v;
              end
              is_id_v: begin
                state_d = ST_ID;
                sout_d  = JEDEC_ID;
                oe_d    = 1'b1;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_LEN - 1)) begin
            cnt_d   = '0;
            fcnt_d  = '0;
            addr_d  = word_v[ADDR_W-1:0];
            req_d   = 1'b1;
            rdy_d   = 1'b0;
            state_d = fast_q ? ST_DUMMY : ST_DATA;
          end
        end
        ST_DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // Shift even when not ready so a late byte lands bit-aligned.
          if (sck_fall) begin
            oe_d   = 1'b1;
            miso_d = rdy_q & sout_q[23];
            sout_d = {sout_q[22:0], 1'b0};
            fcnt_d = fcnt_q + 4'd1;
            if (!rdy_q && fcnt_q == 4'd0) unr_d = 1'b1;
          end
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = '0;
              fcnt_d = '0;
              addr_d = addr_q + 1'b1;
              req_d  = 1'b1;
              rdy_d  = 1'b0;
            end
          end
        end
        ST_ID: if (sck_fall) begin
          miso_d = sout_q[23];
          sout_d = {sout_q[22:0], sout_q[23]};
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    if (!cs_s && req_q && mem_ack &&
        (state_q == ST_DATA || state_q == ST_DUMMY)) begin
      sout_d[23:16] = byte_v;
      rdy_d         = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      unr_q       <= 1'b0;
      rdy_q       <= 1'b0;
      fast_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_b};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      unr_q       <= unr_d;
      rdy_q       <= rdy_d;
      fast_q      <= fast_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign underrun    = unr_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// Self-checking bench for spi_flash_target: SPI initiator,
// memory responder and a byte-level reference model.
module tb_spi_flash_target;

  localparam int          AW  = 19;
  localparam int          HP  = 4;
  localparam logic [23:0] JID = 24'hEF4013;

  logic          clock = 1'b0;
  logic          reset_b = 1'b0;
  logic          spi_sck = 1'b0;
  logic          spi_cs_b = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oe, mem_req, underrun;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_data = 8'h00;

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 1;
  int oe_cnt = 0;
  int req_cnt = 0;
  logic [7:0]    key = 8'h00;
  logic [AW-1:0] req_log[$];

  always #5 clock = ~clock;

  spi_flash_target #(
    .ADDR_W      (AW),
    .JEDEC_ID    (JID),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .reset_b     (reset_b),
    .spi_sck     (spi_sck),
    .spi_cs_b    (spi_cs_b),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .underrun    (underrun)
  );

  function automatic logic [7:0] data_of(input logic [AW-1:0] a);
    return a[7:0] ^ key;
  endfunction

  // Memory stand-in: ack ack_dly cycles after a request is seen.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_req && reset_b) begin
        req_log.push_back(mem_addr);
        repeat (ack_dly - 1) @(negedge clock);
        mem_data = data_of(mem_addr);
        mem_ack  = 1'b1;
        @(negedge clock);
        mem_ack  = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (spi_miso_oe) oe_cnt++;
    if (mem_req) req_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      tick(HP);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      tick(HP);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low;
    spi_cs_b = 1'b0;
    tick(HP);
  endtask

  task automatic cs_high;
    tick(HP);
    spi_cs_b = 1'b1;
    tick(3 * HP);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    xfer(a[23:16], rx);
    xfer(a[15:8], rx);
    xfer(a[7:0], rx);
  endtask

  task automatic run_read(input logic [23:0] a, input int n);
    logic [7:0]    rx;
    logic [AW-1:0] ea;
    req_log.delete();
    cs_low();
    xfer(8'h03, rx);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      ea = a[AW-1:0] + AW'(i);
      xfer(8'h00, rx);
      n_chk++;
      if (rx !== data_of(ea)) begin
        n_fail++;
        $display("FAIL read_byte%0d addr=%h: got %h want %h",
                 i, ea, rx, data_of(ea));
      end
    end
    n_chk++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL read_underrun: got %b want 0", underrun);
    end
    cs_high();
    n_chk++;
    if (req_log.size() != n + 1) begin
      n_fail++;
      $display("FAIL read_req_count: got %0d want %0d",
               req_log.size(), n + 1);
    end else begin
      for (int i = 0; i <= n; i++) begin
        ea = a[AW-1:0] + AW'(i);
        n_chk++;
        if (req_log[i] !== ea) begin
          n_fail++;
          $display("FAIL read_addr%0d: got %h want %h", i, req_log[i], ea);
        end
      end
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_chk++;
    if ({spi_miso, spi_miso_oe, mem_req, underrun} !== 4'b1000 ||
        mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got miso=%b oe=%b req=%b unr=%b addr=%h",
               spi_miso, spi_miso_oe, mem_req, underrun, mem_addr);
    end
    reset_b = 1'b1;
    tick(4);
  endtask

  task automatic test_read;
    key = 8'hBC;
    run_read(24'h00CAFE, 2);
  endtask

  task automatic test_wrap;
    key = 8'($urandom);
    run_read(24'h07FFFF, 2);
  endtask

  task automatic test_random_reads;
    for (int k = 0; k < 4; k++) begin
      key = 8'($urandom);
      run_read(24'($urandom), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_jedec;
    logic [7:0]  rx;
    logic [23:0] r;
    int          n, base;
    for (int k = 0; k < 2; k++) begin
      n    = (k == 0) ? 4 : int'($urandom_range(5, 7));
      base = req_cnt;
      cs_low();
      xfer(8'h9F, rx);
      for (int i = 0; i < n; i++) begin
        xfer(8'($urandom), rx);
        r = JID >> (8 * (2 - (i % 3)));
        n_chk++;
        if (rx !== r[7:0]) begin
          n_fail++;
          $display("FAIL jedec_byte%0d: got %h want %h", i, rx, r[7:0]);
        end
      end
      n_chk++;
      if (spi_miso_oe !== 1'b1) begin
        n_fail++;
        $display("FAIL jedec_oe: got %b want 1", spi_miso_oe);
      end
      cs_high();
      n_chk++;
      if (req_cnt != base) begin
        n_fail++;
        $display("FAIL jedec_no_req: got %0d req cycles want 0", req_cnt - base);
      end
    end
  endtask

  task automatic test_ignore;
    logic [7:0] rx;
    int         oe_b, req_b;
    oe_b  = oe_cnt;
    req_b = req_cnt;
    cs_low();
    xfer(8'hFF, rx);
    xfer(8'($urandom), rx);
    cs_high();
    n_chk++;
    if (oe_cnt != oe_b || req_cnt != req_b) begin
      n_fail++;
      $display("FAIL ignore_quiet: got oe=%0d req=%0d cycles want 0 0",
               oe_cnt - oe_b, req_cnt - req_b);
    end
    key = 8'($urandom);
    run_read(24'($urandom), 1);
  endtask

  task automatic test_fast_read;
    logic [7:0]    rx;
    logic [23:0]   a;
    logic [AW-1:0] ea;
    int            oe_b, req_b;
    a     = 24'($urandom);
    key   = 8'($urandom);
    oe_b  = oe_cnt;
    req_b = req_cnt;
    cs_low();
    xfer(8'h0B, rx);
    send_addr(a);
`ifdef FAST_READ_EN
    xfer(8'h00, rx);
    for (int i = 0; i < 2; i++) begin
      ea = a[AW-1:0] + AW'(i);
      xfer(8'h00, rx);
      n_chk++;
      if (rx !== data_of(ea)) begin
        n_fail++;
        $display("FAIL fast_byte%0d: got %h want %h", i, rx, data_of(ea));
      end
    end
    cs_high();
`else
    xfer(8'h00, rx);
    cs_high();
    ea = '0;
    n_chk++;
    if (oe_cnt != oe_b || req_cnt != req_b || ea !== '0) begin
      n_fail++;
      $display("FAIL fast_ignored: got oe=%0d req=%0d cycles want 0 0",
               oe_cnt - oe_b, req_cnt - req_b);
    end
`endif
  endtask

  task automatic test_underrun;
    logic [7:0]    rx;
    logic [23:0]   a;
    logic [AW-1:0] ea;
    logic [7:0]    d;
    a       = 24'($urandom);
    a[7:0]  = 8'($urandom_range(0, 126));
    key     = {1'b1, 7'($urandom)};
    ack_dly = 10;
    cs_low();
    xfer(8'h03, rx);
    send_addr(a);
    for (int i = 0; i < 2; i++) begin
      ea = a[AW-1:0] + AW'(i);
      d  = data_of(ea);
      xfer(8'h00, rx);
      n_chk++;
      if (rx !== {1'b0, d[6:0]}) begin
        n_fail++;
        $display("FAIL underrun_byte%0d: got %h want %h", i, rx, {1'b0, d[6:0]});
      end
    end
    n_chk++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set: got %b want 1", underrun);
    end
    cs_high();
    n_chk++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
    tick(20);
    ack_dly = 1;
  endtask

  task automatic test_abort;
    logic [7:0] rx;
    int         w;
    ack_dly = 60;
    cs_low();
    xfer(8'h03, rx);
    send_addr(24'($urandom));
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b0;
      tick(HP);
      spi_sck = 1'b1;
      tick(HP);
      spi_sck = 1'b0;
    end
    n_chk++;
    if (spi_miso_oe !== 1'b1 || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got oe=%b unr=%b want 1 1", spi_miso_oe, underrun);
    end
    spi_cs_b = 1'b1;
    tick(4);
    n_chk++;
    if (spi_miso_oe !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_cs: got oe=%b req=%b want 0 1", spi_miso_oe, mem_req);
    end
    w = 0;
    while (mem_req && w < 100) begin
      tick(1);
      w++;
    end
    n_chk++;
    if (mem_req !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_req_drop: got req=%b unr=%b after %0d cycles want 0 0",
               mem_req, underrun, w);
    end
    tick(4);
    ack_dly = 1;
    key = 8'($urandom);
    run_read(24'($urandom), 2);
  endtask

  task automatic test_reset_mid;
    logic [7:0]  rx;
    logic [23:0] a;
    ack_dly = 60;
    a = {5'h0, 19'($urandom_range(1, 'h7FFFF))};
    cs_low();
    xfer(8'h03, rx);
    send_addr(a);
    for (int i = 0; i < 2; i++) begin
      tick(HP);
      spi_sck = 1'b1;
      tick(HP);
      spi_sck = 1'b0;
    end
    reset_b = 1'b0;
    #1;
    n_chk++;
    if ({spi_miso, spi_miso_oe, mem_req, underrun} !== 4'b1000 ||
        mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got miso=%b oe=%b req=%b unr=%b addr=%h",
               spi_miso, spi_miso_oe, mem_req, underrun, mem_addr);
    end
    spi_cs_b = 1'b1;
    tick(3);
    reset_b = 1'b1;
    tick(80);
    ack_dly = 1;
    key = 8'($urandom);
    run_read(24'($urandom), 1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_wrap();
    test_jedec();
    test_ignore();
    test_fast_read();
    test_random_reads();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
